// File: rtl/fetch_queue.sv
// Decoupling FIFO from fetch/decode to reservation-station dispatch, with flush and a halt latch.
// Optional FETCHQ_BYPASS_EN: an empty queue forwards a push straight to pop_* in the same cycle.
module fetch_queue #(
    parameter int DEPTH  = 8,
    parameter int REG_W  = 6,
    parameter int WORD_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [2:0]               push_unit,
    input  logic [REG_W-1:0]         push_reg1,
    input  logic [REG_W-1:0]         push_reg2,
    input  logic [REG_W-1:0]         push_reg3,
    input  logic                     push_hasimm,
    input  logic [WORD_W-1:0]        push_imm,
    output logic                     pop_valid,
    input  logic                     pop_ready,
    output logic [2:0]               pop_unit,
    output logic [REG_W-1:0]         pop_reg1,
    output logic [REG_W-1:0]         pop_reg2,
    output logic [REG_W-1:0]         pop_reg3,
    output logic                     pop_hasimm,
    output logic [WORD_W-1:0]        pop_imm,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     halted
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 3 + 3 * REG_W + 1 + WORD_W;
    localparam logic [2:0] UNIT_HALT = 3'b101;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               halted_q, halted_d;

    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] pop_entry;
    logic               mem_valid;
    logic               bypass;
    logic               push_fire;
    logic               pop_fire;
    logic               wr_en;
    logic               rd_en;

    assign push_entry = {push_unit, push_reg1, push_reg2, push_reg3, push_hasimm, push_imm};

    always_comb begin
        push_ready = (count_q != CNT_W'(DEPTH)) && !halted_q && !flush;
        mem_valid  = (count_q != '0) && !flush;
        bypass     = 1'b0;
`ifdef FETCHQ_BYPASS_EN
        bypass     = (count_q == '0) && push_valid && pop_ready && push_ready && !rst;
`endif
        pop_valid  = mem_valid || bypass;

        // pop_* must read as zero whenever nothing is being offered
        pop_entry = '0;
        if (bypass) begin
            pop_entry = push_entry;
        end else if (mem_valid) begin
            pop_entry = mem_q[head_q];
        end

        push_fire = push_valid && push_ready;
        pop_fire  = pop_valid && pop_ready;
        wr_en     = push_fire && !bypass;
        rd_en     = pop_fire && !bypass;

        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        halted_d = halted_q;
        if (flush) begin
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            halted_d = 1'b0;
        end else begin
            if (wr_en) begin
                tail_d = tail_q + 1'b1;
            end
            if (rd_en) begin
                head_d = head_q + 1'b1;
            end
            count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
            if (push_fire && (push_unit == UNIT_HALT)) begin
                halted_d = 1'b1;
            end
        end
    end

    assign {pop_unit, pop_reg1, pop_reg2, pop_reg3, pop_hasimm, pop_imm} = pop_entry;
    assign count  = count_q;
    assign halted = halted_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            halted_q <= halted_d;
        end
    end

    // Storage has no reset; occupancy tracking alone decides what is valid
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[tail_q] <= push_entry;
        end
    end

endmodule
